// File: rtl/fifo_read_stream_adapter_if.sv
// Signal bundle between the async FIFO read port, the read-stream adapter and its consumer.
// master = adapter side, slave = FIFO/consumer environment side.
interface fifo_read_stream_adapter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_r_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              flush;
    logic [CNT_W-1:0]  xfer_count;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready, flush,
        output fifo_r_en, m_valid, m_data, xfer_count
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready, flush,
        input  fifo_r_en, m_valid, m_data, xfer_count
    );
endinterface

// File: rtl/fifo_read_stream_adapter.sv
// Read-domain stage behind the async FIFO: issues reads from the empty flag, absorbs the 1-cycle
// RAM latency in a small circular skid buffer and presents words as a valid/ready stream.
module fifo_read_stream_adapter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BUF_DEPTH = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         rclk,
    input  logic                         rrst,
    fifo_read_stream_adapter_if.master   bus
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_V  = (OCC_W + 1)'(BUF_DEPTH);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [OCC_W-1:0]  occ_q;
    logic              inflight_q;
    logic              run_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              r_en;
    logic              push;
    logic              pop;
    logic [OCC_W:0]    committed;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Space is counted including the word already in flight, so a push can never overflow.
    // run_q keeps the read enable low while reset is held and for the release edge.
    always_comb begin
        committed = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
        r_en      = run_q && !bus.fifo_empty && !bus.flush && (committed < DEPTH_V);
        push      = inflight_q && !bus.flush;
        pop       = (occ_q != '0) && bus.m_ready && !bus.flush;
    end

    assign bus.fifo_r_en  = r_en;
    assign bus.m_valid    = (occ_q != '0);
    assign bus.m_data     = mem_q[head_q];
    assign bus.xfer_count = cnt_q;

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= r_en;
            if (bus.flush) begin
                // The word returning this cycle is dropped by not pushing it.
                occ_q  <= '0;
                head_q <= tail_q;
            end else begin
                if (push) begin
                    mem_q[tail_q] <= bus.fifo_rdata;
                    tail_q        <= next_ptr(tail_q);
                end
                if (pop) begin
                    head_q <= next_ptr(head_q);
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                case ({push, pop})
                    2'b10:   occ_q <= occ_q + OCC_W'(1);
                    2'b01:   occ_q <= occ_q - OCC_W'(1);
                    default: occ_q <= occ_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Directed bench for fifo_read_stream_adapter with a queue-based FIFO model (1-cycle read latency).
// Runs with CNT_W=4 so the transfer counter wrap is reachable.
module tb_fifo_read_stream_adapter;
    logic rclk;
    logic rrst;
    int   n_pass;
    int   n_total;
    int   viol;

    logic [31:0] fq[$];
    bit          sparse;
    bit          tgl;

    fifo_read_stream_adapter_if #(.DATA_W(32), .CNT_W(4)) bus ();

    fifo_read_stream_adapter #(
        .DATA_W    (32),
        .BUF_DEPTH (3),
        .CNT_W     (4)
    ) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO model: rdata appears the cycle after a read-enable cycle; empty is registered.
    always @(posedge rclk) begin
        if (bus.fifo_r_en && fq.size() > 0) bus.fifo_rdata <= fq.pop_front();
        bus.fifo_empty <= (fq.size() == 0) || (sparse && !tgl);
        tgl            <= !tgl;
    end

    always @(negedge rclk) begin
        if (rrst && bus.fifo_r_en && bus.fifo_empty) viol <= viol + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rrst = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back(32'hA0 + 32'(i));
        repeat (3) @(posedge rclk);
        #1;
        n_total++;
        if (bus.fifo_r_en !== 1'b0) $display("FAIL reset_r_en: got %b want 0", bus.fifo_r_en);
        else n_pass++;
        n_total++;
        if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid);
        else n_pass++;
        n_total++;
        if (bus.m_data !== 32'h0) $display("FAIL reset_m_data: got %h want 0", bus.m_data);
        else n_pass++;
        n_total++;
        if (bus.xfer_count !== 4'h0) $display("FAIL reset_count: got %0d want 0", bus.xfer_count);
        else n_pass++;
    endtask

    task automatic test_streaming();
        bit          ren [20];
        bit          vld [20];
        logic [31:0] dat [20];
        int rf = -1, rl = -1, rc = 0, vf = -1, vl = -1, vc = 0, k = 0;
        rrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            ren[i] = bus.fifo_r_en;
            vld[i] = bus.m_valid;
            dat[i] = bus.m_data;
        end
        for (int i = 0; i < 20; i++) begin
            if (ren[i]) begin
                if (rf < 0) rf = i;
                rl = i;
                rc++;
            end
            if (vld[i]) begin
                if (vf < 0) vf = i;
                vl = i;
                vc++;
                n_total++;
                if (dat[i] !== 32'hA0 + 32'(k))
                    $display("FAIL stream_data[%0d]: got %h want %h", k, dat[i], 32'hA0 + 32'(k));
                else n_pass++;
                k++;
            end
        end
        n_total++;
        if (rf !== 1 || rl !== 8 || rc !== 8)
            $display("FAIL stream_r_en: first %0d last %0d count %0d want 1 8 8", rf, rl, rc);
        else n_pass++;
        n_total++;
        if (vf !== 3 || vl !== 10 || vc !== 8)
            $display("FAIL stream_valid: first %0d last %0d count %0d want 3 10 8", vf, vl, vc);
        else n_pass++;
        n_total++;
        if (bus.xfer_count !== 4'd8)
            $display("FAIL stream_count: got %0d want 8", bus.xfer_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int rc = 0, bad = 0;
        logic [31:0] got[$];
        tick();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 12; i++) begin
            @(negedge rclk);
            if (bus.fifo_r_en) rc++;
            if (bus.m_valid && bus.m_data !== 32'hA0) bad++;
        end
        n_total++;
        if (rc !== 3) $display("FAIL bp_r_en_pulses: got %0d want 3", rc);
        else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL bp_head_stable: %0d unstable samples want 0", bad);
        else n_pass++;
        n_total++;
        if (bus.m_valid !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", bus.m_valid);
        else n_pass++;
        tick();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
        end
        n_total++;
        if (got.size() !== 8) $display("FAIL bp_drain_count: got %0d want 8", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_total++;
            if (got[i] !== 32'hA0 + 32'(i))
                $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], 32'hA0 + 32'(i));
            else n_pass++;
        end
        n_total++;
        if (bus.xfer_count !== 4'd0) $display("FAIL bp_count_wrap: got %0d want 0", bus.xfer_count);
        else n_pass++;
    endtask

    task automatic test_flush_inflight();
        bit found = 1'b0;
        logic [31:0] got[$];
        tick();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(32'hC0 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            if (bus.fifo_r_en) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL flush_first_read: got no r_en want r_en within 10 cycles");
        else n_pass++;
        tick();
        bus.flush = 1'b1;
        @(negedge rclk);
        n_total++;
        if (bus.fifo_r_en !== 1'b0) $display("FAIL flush_r_en: got %b want 0", bus.fifo_r_en);
        else n_pass++;
        tick();
        bus.flush = 1'b0;
        @(negedge rclk);
        n_total++;
        if (bus.m_valid !== 1'b0) $display("FAIL flush_valid_n2: got %b want 0", bus.m_valid);
        else n_pass++;
        for (int i = 0; i < 15; i++) begin
            @(negedge rclk);
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
        end
        n_total++;
        if (got.size() !== 3) $display("FAIL flush_deliver_count: got %0d want 3", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_total++;
            if (got[i] !== 32'hC1 + 32'(i))
                $display("FAIL flush_data[%0d]: got %h want %h", i, got[i], 32'hC1 + 32'(i));
            else n_pass++;
        end
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_total++;
        if (bus.xfer_count !== 4'd3) $display("FAIL flush_count_kept: got %0d want 3", bus.xfer_count);
        else n_pass++;
    endtask

    task automatic test_sparse_empty();
        logic [31:0] got[$];
        tick();
        sparse = 1'b1;
        viol   = 0;
        for (int i = 0; i < 10; i++) fq.push_back(32'hD0 + 32'(i));
        for (int i = 0; i < 75; i++) begin
            tick();
            bus.m_ready = (i >= 60) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge rclk);
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
        end
        sparse = 1'b0;
        n_total++;
        if (got.size() !== 10) $display("FAIL sparse_count: got %0d want 10", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_total++;
            if (got[i] !== 32'hD0 + 32'(i))
                $display("FAIL sparse_data[%0d]: got %h want %h", i, got[i], 32'hD0 + 32'(i));
            else n_pass++;
        end
        n_total++;
        if (viol !== 0) $display("FAIL sparse_r_en_while_empty: got %0d want 0", viol);
        else n_pass++;
        n_total++;
        if (bus.xfer_count !== 4'd13) $display("FAIL sparse_xfer: got %0d want 13", bus.xfer_count);
        else n_pass++;
    endtask

    task automatic test_wrap_reset();
        logic [31:0] got[$];
        logic [31:0] got2[$];
        tick();
        rrst = 1'b0;
        fq.delete();
        tick();
        rrst = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) fq.push_back(32'h100 + 32'(i));
        for (int i = 0; i < 40; i++) begin
            @(negedge rclk);
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
        end
        n_total++;
        if (got.size() !== 17) $display("FAIL wrap_transfers: got %0d want 17", got.size());
        else n_pass++;
        n_total++;
        if (bus.xfer_count !== 4'd1) $display("FAIL wrap_count: got %0d want 1", bus.xfer_count);
        else n_pass++;
        tick();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back(32'h200 + 32'(i));
        repeat (5) tick();
        n_total++;
        if (bus.m_valid !== 1'b1) $display("FAIL midburst_valid: got %b want 1", bus.m_valid);
        else n_pass++;
        rrst = 1'b0;
        fq.delete();
        #1;
        n_total++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 32'h0 || bus.fifo_r_en !== 1'b0 ||
            bus.xfer_count !== 4'd0)
            $display("FAIL midburst_reset: valid %b data %h r_en %b count %0d want 0 0 0 0",
                     bus.m_valid, bus.m_data, bus.fifo_r_en, bus.xfer_count);
        else n_pass++;
        tick();
        rrst = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) fq.push_back(32'h300 + 32'(i));
        for (int i = 0; i < 15; i++) begin
            @(negedge rclk);
            if (bus.m_valid && bus.m_ready) got2.push_back(bus.m_data);
        end
        n_total++;
        if (got2.size() !== 3) $display("FAIL restart_count: got %0d want 3", got2.size());
        else n_pass++;
        for (int i = 0; i < got2.size() && i < 3; i++) begin
            n_total++;
            if (got2[i] !== 32'h300 + 32'(i))
                $display("FAIL restart_data[%0d]: got %h want %h", i, got2[i], 32'h300 + 32'(i));
            else n_pass++;
        end
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        viol            = 0;
        sparse          = 1'b0;
        tgl             = 1'b0;
        rrst            = 1'b0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_rdata  = '0;
        bus.m_ready     = 1'b1;
        bus.flush       = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_inflight();
        test_sparse_empty();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
